// File: rtl/tag_ram_ctrl.sv
// Tag RAM controller: arbitrates lookup/update onto a single-port sync-read RAM,
// runs a full-array flush, and returns hit/miss for lookups one cycle after the read.
module tag_ram_ctrl #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush_req,
  output logic              flush_busy,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [AWIDTH-1:0] lk_addr,
  input  logic [DWIDTH-2:0] lk_tag,
  output logic              lk_rsp_valid,
  output logic              lk_rsp_hit,
  output logic [DWIDTH-1:0] lk_rsp_data,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [AWIDTH-1:0] up_addr,
  input  logic [DWIDTH-2:0] up_tag,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DWIDTH-2:0] lk_tag_q, lk_tag_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;

  // Grants are suppressed while reset is asserted so no write can slip out
  // combinationally during an asynchronous reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    rd_pend_d  = 1'b0;
    lk_tag_d   = lk_tag_q;
    flush_busy = 1'b0;
    lk_ready   = 1'b0;
    up_ready   = 1'b0;
    ram_we     = 1'b0;
    ram_din    = '0;
    ram_addr   = addr_q;
    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else if (lk_valid && (!up_valid || !rr_q)) begin
            lk_ready  = 1'b1;
            ram_addr  = lk_addr;
            rd_pend_d = 1'b1;
            lk_tag_d  = lk_tag;
            if (up_valid) rr_d = ~rr_q;
          end else if (up_valid) begin
            up_ready = 1'b1;
            ram_addr = up_addr;
            ram_din  = {1'b1, up_tag};
            ram_we   = 1'b1;
            if (lk_valid) rr_d = ~rr_q;
          end
        end
        S_FLUSH: begin
          flush_busy = 1'b1;
          ram_we     = 1'b1;
          ram_din    = '0;
          ram_addr   = cnt_q;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    addr_d = ram_addr;
  end

  always_comb begin
    rsp_valid_d = rd_pend_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_data_d  = rsp_data_q;
    if (rd_pend_q) begin
      rsp_data_d = ram_dout;
      rsp_hit_d  = ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0] == lk_tag_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      lk_tag_q    <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      rd_pend_q   <= rd_pend_d;
      lk_tag_q    <= lk_tag_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign lk_rsp_valid = rsp_valid_q;
  assign lk_rsp_hit   = rsp_hit_q;
  assign lk_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed testbench for tag_ram_ctrl with a behavioural sync-read RAM model.
module tb_tag_ram_ctrl;

  localparam int unsigned AWIDTH = 3;
  localparam int unsigned DWIDTH = 7;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_busy;
  logic              lk_valid = 1'b0;
  logic              lk_ready;
  logic [AWIDTH-1:0] lk_addr = '0;
  logic [DWIDTH-2:0] lk_tag = '0;
  logic              lk_rsp_valid;
  logic              lk_rsp_hit;
  logic [DWIDTH-1:0] lk_rsp_data;
  logic              up_valid = 1'b0;
  logic              up_ready;
  logic [AWIDTH-1:0] up_addr = '0;
  logic [DWIDTH-2:0] up_tag = '0;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout = '0;

  logic [DWIDTH-1:0] mem [1<<AWIDTH];

  int n_checks = 0;
  int n_pass   = 0;

  tag_ram_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_tag(lk_tag),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_hit(lk_rsp_hit), .lk_rsp_data(lk_rsp_data),
    .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_tag(up_tag),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Read-first single-port RAM: dout reflects the entry addressed at the last edge.
  always @(posedge clock) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (flush_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", flush_busy); else n_pass++;
    n_checks++; if (lk_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", lk_rsp_valid); else n_pass++;
    n_checks++; if (lk_rsp_hit !== 1'b0) $display("FAIL reset_rsp_hit got %b exp 0", lk_rsp_hit); else n_pass++;
    n_checks++; if (lk_rsp_data !== 7'h00) $display("FAIL reset_rsp_data got %h exp 00", lk_rsp_data); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    // traffic, then flush, then reset mid-flush with an update still requesting
    up_valid = 1'b1; up_addr = 3'd1; up_tag = 6'h03;
    step();
    up_valid = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    up_valid = 1'b1;
    step(); step();
    n_checks++; if (flush_busy !== 1'b1) $display("FAIL midflush_busy got %b exp 1", flush_busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (flush_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", flush_busy); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_we got %b exp 0", ram_we); else n_pass++;
    n_checks++; if (lk_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", lk_rsp_valid); else n_pass++;
    step();
    up_valid = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_update_lookup();
    up_valid = 1'b1; up_addr = 3'd5; up_tag = 6'h2A;
    #1;
    n_checks++; if (up_ready !== 1'b1) $display("FAIL up_ready got %b exp 1", up_ready); else n_pass++;
    n_checks++; if (ram_we !== 1'b1) $display("FAIL up_we got %b exp 1", ram_we); else n_pass++;
    n_checks++; if (ram_din !== 7'h6A) $display("FAIL up_din got %h exp 6a", ram_din); else n_pass++;
    n_checks++; if (ram_addr !== 3'd5) $display("FAIL up_addr got %0d exp 5", ram_addr); else n_pass++;
    step();
    up_valid = 1'b0;
    lk_valid = 1'b1; lk_addr = 3'd5; lk_tag = 6'h2A;
    #1;
    n_checks++; if (lk_ready !== 1'b1) $display("FAIL lk_ready got %b exp 1", lk_ready); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL lk_we got %b exp 0", ram_we); else n_pass++;
    step();
    lk_valid = 1'b0;
    n_checks++; if (lk_rsp_valid !== 1'b0) $display("FAIL hit_early_valid got %b exp 0", lk_rsp_valid); else n_pass++;
    step();
    n_checks++; if (lk_rsp_valid !== 1'b1) $display("FAIL hit_valid got %b exp 1", lk_rsp_valid); else n_pass++;
    n_checks++; if (lk_rsp_hit !== 1'b1) $display("FAIL hit_hit got %b exp 1", lk_rsp_hit); else n_pass++;
    n_checks++; if (lk_rsp_data !== 7'h6A) $display("FAIL hit_data got %h exp 6a", lk_rsp_data); else n_pass++;
    step();
    n_checks++; if (lk_rsp_valid !== 1'b0) $display("FAIL hit_strobe_len got %b exp 0", lk_rsp_valid); else n_pass++;
  endtask

  task automatic test_miss();
    lk_valid = 1'b1; lk_addr = 3'd5; lk_tag = 6'h2B;
    step();
    lk_valid = 1'b0;
    step();
    n_checks++; if (lk_rsp_valid !== 1'b1) $display("FAIL miss_valid got %b exp 1", lk_rsp_valid); else n_pass++;
    n_checks++; if (lk_rsp_hit !== 1'b0) $display("FAIL miss_hit got %b exp 0", lk_rsp_hit); else n_pass++;
    n_checks++; if (lk_rsp_data !== 7'h6A) $display("FAIL miss_data got %h exp 6a", lk_rsp_data); else n_pass++;
    step();
  endtask

  task automatic test_contention();
    logic [3:0] exp_lk;
    exp_lk = 4'b0101;  // bit i = lookup wins on cycle i
    lk_valid = 1'b1; lk_addr = 3'd5; lk_tag = 6'h2A;
    up_valid = 1'b1; up_addr = 3'd3; up_tag = 6'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (lk_ready !== exp_lk[i] || up_ready !== !exp_lk[i])
        $display("FAIL contention_%0d got lk=%b up=%b exp lk=%b up=%b", i, lk_ready, up_ready, exp_lk[i], !exp_lk[i]);
      else n_pass++;
      step();
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    up_valid = 1'b1; up_addr = 3'd2; up_tag = 6'h15;
    step();
    up_valid = 1'b0;
    lk_valid = 1'b1; lk_addr = 3'd2; lk_tag = 6'h15;
    step();
    lk_tag = 6'h14;
    #1;
    n_checks++; if (lk_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", lk_ready); else n_pass++;
    step();
    lk_valid = 1'b0;
    n_checks++;
    if (lk_rsp_valid !== 1'b1 || lk_rsp_hit !== 1'b1 || lk_rsp_data !== 7'h55)
      $display("FAIL b2b_rsp0 got v=%b h=%b d=%h exp v=1 h=1 d=55", lk_rsp_valid, lk_rsp_hit, lk_rsp_data);
    else n_pass++;
    step();
    n_checks++;
    if (lk_rsp_valid !== 1'b1 || lk_rsp_hit !== 1'b0 || lk_rsp_data !== 7'h55)
      $display("FAIL b2b_rsp1 got v=%b h=%b d=%h exp v=1 h=0 d=55", lk_rsp_valid, lk_rsp_hit, lk_rsp_data);
    else n_pass++;
    step();
    n_checks++; if (lk_rsp_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", lk_rsp_valid); else n_pass++;
  endtask

  task automatic test_flush_after_lookup();
    int guard;
    lk_valid = 1'b1; lk_addr = 3'd2; lk_tag = 6'h15;
    step();
    lk_valid = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n_checks++;
    if (lk_rsp_valid !== 1'b1 || lk_rsp_hit !== 1'b1 || lk_rsp_data !== 7'h55)
      $display("FAIL preflush_rsp got v=%b h=%b d=%h exp v=1 h=1 d=55", lk_rsp_valid, lk_rsp_hit, lk_rsp_data);
    else n_pass++;
    n_checks++; if (flush_busy !== 1'b1) $display("FAIL preflush_busy got %b exp 1", flush_busy); else n_pass++;
    guard = 0;
    while (flush_busy === 1'b1 && guard < 20) begin step(); guard++; end
    n_checks++; if (guard !== 8) $display("FAIL preflush_len got %0d exp 8", guard); else n_pass++;
  endtask

  task automatic test_flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    lk_valid = 1'b1; lk_addr = 3'd5; lk_tag = 6'h2A;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (flush_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== i[AWIDTH-1:0] || ram_din !== 7'h00 || lk_ready !== 1'b0)
        $display("FAIL flush_cyc%0d got busy=%b we=%b addr=%0d din=%h lkr=%b exp 1 1 %0d 00 0",
                 i, flush_busy, ram_we, ram_addr, ram_din, lk_ready, i);
      else n_pass++;
      step();
    end
    n_checks++; if (flush_busy !== 1'b0) $display("FAIL flush_done got %b exp 0", flush_busy); else n_pass++;
    n_checks++; if (lk_ready !== 1'b1) $display("FAIL flush_lk_resume got %b exp 1", lk_ready); else n_pass++;
    step();
    lk_valid = 1'b0;
    step();
    n_checks++;
    if (lk_rsp_valid !== 1'b1 || lk_rsp_hit !== 1'b0 || lk_rsp_data !== 7'h00)
      $display("FAIL flush_lookup got v=%b h=%b d=%h exp v=1 h=0 d=00", lk_rsp_valid, lk_rsp_hit, lk_rsp_data);
    else n_pass++;
    step();
  endtask

  task automatic test_flush_edge();
    int busy_cnt;
    int guard;
    flush_req = 1'b1;
    lk_valid = 1'b1; lk_addr = 3'd5; lk_tag = 6'h00;
    #1;
    n_checks++; if (lk_ready !== 1'b0 || ram_we !== 1'b0) $display("FAIL flush_prio got lkr=%b we=%b exp 0 0", lk_ready, ram_we); else n_pass++;
    step();
    flush_req = 1'b0;
    busy_cnt = 0;
    guard = 0;
    while (flush_busy === 1'b1 && guard < 20) begin
      flush_req = (busy_cnt == 3);
      if (lk_ready !== 1'b0) begin
        n_checks++;
        $display("FAIL flush_edge_stall got lk_ready=%b exp 0 at busy %0d", lk_ready, busy_cnt);
      end
      step();
      busy_cnt++;
      guard++;
    end
    flush_req = 1'b0;
    n_checks++; if (busy_cnt !== 8) $display("FAIL flush_edge_len got %0d exp 8", busy_cnt); else n_pass++;
    #1;
    n_checks++; if (lk_ready !== 1'b1 || flush_busy !== 1'b0) $display("FAIL flush_edge_resume got lkr=%b busy=%b exp 1 0", lk_ready, flush_busy); else n_pass++;
    step();
    lk_valid = 1'b0;
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = '0;
    #2;
    test_reset();
    test_update_lookup();
    test_miss();
    test_contention();
    test_back_to_back();
    test_flush_after_lookup();
    test_flush();
    test_flush_edge();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
